// File: rtl/target_hit_judge_pkg.sv
// Shared constants and slot state type for the target hit judge.
package ewh_pkg;
  localparam logic [3:0] NO_TARGET   = 4'd10;
  localparam int         SCORE_MAX   = 9999;
  localparam int         MISS_POINTS = 50;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ARMED  = 2'd1,
    FLASH  = 2'd2,
    LOCKED = 2'd3
  } slot_state_e;
endpackage

// File: rtl/target_hit_judge_if.sv
// Hit record handshake between the judge (master) and the game controller (slave).
interface target_hit_judge_if;
  logic       hit_valid;
  logic       hit_ready;
  logic [3:0] hit_index;
  logic       hit_slot;

  modport master (output hit_valid, output hit_index, output hit_slot, input hit_ready);
  modport slave  (input hit_valid, input hit_index, input hit_slot, output hit_ready);
endinterface

// File: rtl/target_hit_judge_debounce.sv
// Per-channel 2-flop synchronizer, stability counter and filtered falling-edge pulse.
module photo_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic fall_o
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          s1_q, s2_q, filt_q;
  logic [CW-1:0] cnt_q;
  logic          settle;

  // Pulse is raised in the cycle whose edge commits the filtered 1->0 change.
  assign settle = (s2_q != filt_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
  assign fall_o = settle && filt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
      if (s2_q == filt_q) begin
        cnt_q <= '0;
      end else if (settle) begin
        filt_q <= s2_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/target_hit_judge.sv
// Debounced photodiode hit judge with two target slots, LED blink and scored hit handshake.
// Optional build macro MISS_PENALTY_EN: hits on unarmed channels deduct points.
module target_hit_judge
  import ewh_pkg::*;
#(
  parameter int NUM_TARGETS     = 10,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int FLASH_CYCLES    = 12500000,
  parameter int HIT_POINTS      = 100,
  parameter int SCORE_MAX       = ewh_pkg::SCORE_MAX
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_TARGETS-1:0] photo_array,
  input  logic [3:0]             target_a,
  input  logic [3:0]             target_b,
  output logic [NUM_TARGETS-1:0] target_leds,
  target_hit_judge_if.master     hit_if,
  output logic [31:0]            score
);
  localparam int TICK = (FLASH_CYCLES / 8 > 1) ? FLASH_CYCLES / 8 : 1;
  localparam int TW   = (TICK > 1) ? $clog2(TICK) : 1;

  logic [NUM_TARGETS-1:0] fall;
  slot_state_e            state_q [2];
  slot_state_e            state_d [2];
  logic [TW-1:0]          tick_q [2];
  logic [TW-1:0]          tick_d [2];
  logic [2:0]             tog_q [2];
  logic [2:0]             tog_d [2];
  logic [1:0][3:0]        idx_q, idx_in, pidx_q;
  logic [1:0]             chg, hit, pend_q, take;
  logic                   valid_q, oslot_q, load, fire;
  logic [3:0]             oidx_q;
  logic [31:0]            score_q;
  logic signed [33:0]     score_sum;

  for (genvar i = 0; i < NUM_TARGETS; i++) begin : g_deb
    photo_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clock (clock),
      .reset (reset),
      .raw_i (photo_array[i]),
      .fall_o(fall[i])
    );
  end

  function automatic logic [31:0] clamp_score(input logic signed [33:0] v);
    if (v < 0) return '0;
    if (v > $signed(34'(SCORE_MAX))) return 32'(SCORE_MAX);
    return v[31:0];
  endfunction

  // A duplicate of slot A's live target leaves slot B empty.
  assign idx_in[0] = target_a;
  assign idx_in[1] = (target_b == target_a && target_a < NO_TARGET) ? NO_TARGET : target_b;

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      chg[s] = idx_in[s] != idx_q[s];
      hit[s] = !chg[s] && (state_q[s] == ARMED) && fall[idx_q[s]];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        state_q[s] <= EMPTY;
        tick_q[s]  <= '0;
        tog_q[s]   <= '0;
        idx_q[s]   <= NO_TARGET;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        state_q[s] <= state_d[s];
        tick_q[s]  <= tick_d[s];
        tog_q[s]   <= tog_d[s];
        idx_q[s]   <= idx_in[s];
      end
    end
  end

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      state_d[s] = state_q[s];
      tick_d[s]  = tick_q[s];
      tog_d[s]   = tog_q[s];
      if (chg[s]) begin
        state_d[s] = (idx_in[s] < NO_TARGET) ? ARMED : EMPTY;
      end else begin
        case (state_q[s])
          ARMED: if (hit[s]) begin
            state_d[s] = FLASH;
            tick_d[s]  = '0;
            tog_d[s]   = '0;
          end
          FLASH: if (tick_q[s] == TW'(TICK - 1)) begin
            tick_d[s] = '0;
            if (tog_q[s] == 3'd7) state_d[s] = LOCKED;
            else                  tog_d[s]   = tog_q[s] + 3'd1;
          end else begin
            tick_d[s] = tick_q[s] + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Odd blink phases light the LED, so the blink starts dark.
  always_comb begin
    target_leds = '0;
    for (int s = 0; s < 2; s++) begin
      if (state_q[s] == ARMED || (state_q[s] == FLASH && tog_q[s][0]))
        target_leds[idx_q[s]] = 1'b1;
    end
  end

  assign fire    = valid_q && hit_if.hit_ready;
  assign load    = !valid_q || hit_if.hit_ready;
  assign take[0] = load && pend_q[0];
  assign take[1] = load && !pend_q[0] && pend_q[1];

`ifdef MISS_PENALTY_EN
  logic [NUM_TARGETS-1:0] armed_mask;
  logic                   miss;

  always_comb begin
    armed_mask = '0;
    for (int s = 0; s < 2; s++)
      if (state_q[s] == ARMED) armed_mask[idx_q[s]] = 1'b1;
  end
  assign miss = |(fall & ~armed_mask);
`endif

  always_comb begin
    score_sum = $signed({2'b00, score_q});
    if (fire) score_sum = score_sum + $signed(34'(HIT_POINTS));
`ifdef MISS_PENALTY_EN
    if (miss) score_sum = score_sum - $signed(34'(MISS_POINTS));
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_q  <= '0;
      pidx_q  <= '0;
      valid_q <= 1'b0;
      oidx_q  <= '0;
      oslot_q <= 1'b0;
      score_q <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (take[s]) begin
          pend_q[s] <= 1'b0;
        end else if (hit[s] && !pend_q[s]) begin
          pend_q[s] <= 1'b1;
          pidx_q[s] <= idx_q[s];
        end
      end
      if (load) begin
        valid_q <= |pend_q;
        if (pend_q[0]) begin
          oidx_q  <= pidx_q[0];
          oslot_q <= 1'b0;
        end else if (pend_q[1]) begin
          oidx_q  <= pidx_q[1];
          oslot_q <= 1'b1;
        end
      end
      score_q <= clamp_score(score_sum);
    end
  end

  assign hit_if.hit_valid = valid_q;
  assign hit_if.hit_index = oidx_q;
  assign hit_if.hit_slot  = oslot_q;
  assign score            = score_q;
endmodule

// File: tb/tb_target_hit_judge.sv
// Bench for target_hit_judge: directed scenarios plus random stimulus against a time-based reference model.
module tb_target_hit_judge;
  localparam int NT = 10, DB = 4, FL = 16, HP = 100, SMAX = 9999;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [NT-1:0] photo = '1;
  logic [3:0]    ta = 4'd10, tb = 4'd10;
  logic [NT-1:0] leds;
  logic [31:0]   score;

  target_hit_judge_if hif ();

  target_hit_judge #(
    .NUM_TARGETS(NT), .DEBOUNCE_CYCLES(DB), .FLASH_CYCLES(FL),
    .HIT_POINTS(HP), .SCORE_MAX(SMAX)
  ) dut (
    .clock(clock), .reset(reset), .photo_array(photo),
    .target_a(ta), .target_b(tb), .target_leds(leds),
    .hit_if(hif), .score(score)
  );

  always #5 clock = ~clock;

  int errors = 0, checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: slot status with flash start times, pending records, score.
  typedef enum int {M_EMPTY, M_ARMED, M_FLASH, M_LOCKED} mst_e;
  mst_e          mst [2];
  int            midx [2], mstart [2], mpidx [2];
  bit            mpend [2];
  bit            mvalid;
  int            mout_idx, mout_slot, mscore, cyc;
  logic [NT-1:0] mfilt;
  logic [NT-1:0] hist [$];

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      mst[s] = M_EMPTY; midx[s] = 10; mstart[s] = 0; mpend[s] = 0; mpidx[s] = 0;
    end
    mvalid = 0; mout_idx = 0; mout_slot = 0; mscore = 0; cyc = 0;
    mfilt = '1;
    hist.delete();
    repeat (DB + 1) hist.push_back('1);
  endtask

  // The filtered level changes once the raw samples taken 2..DB+1 edges ago all disagree with it.
  task automatic model_update();
    logic [NT-1:0] fall;
    bit allz, allo, miss, fire, load;
    bit chg [2];
    bit hit [2];
    bit opend [2];
    int in [2];
    int ns;
    for (int i = 0; i < NT; i++) begin
      allz = 1; allo = 1;
      for (int j = 0; j < DB; j++) if (hist[j][i]) allz = 0; else allo = 0;
      fall[i] = mfilt[i] && allz;
      if (mfilt[i] && allz) mfilt[i] = 1'b0;
      else if (!mfilt[i] && allo) mfilt[i] = 1'b1;
    end
    hist.push_back(photo);
    void'(hist.pop_front());

    in[0] = ta;
    in[1] = (tb == ta && ta < 10) ? 10 : tb;
    miss = 0;
    for (int i = 0; i < NT; i++)
      if (fall[i] && !((mst[0] == M_ARMED && midx[0] == i) || (mst[1] == M_ARMED && midx[1] == i)))
        miss = 1;
    for (int s = 0; s < 2; s++) begin
      chg[s] = in[s] != midx[s];
      hit[s] = !chg[s] && mst[s] == M_ARMED && fall[midx[s]];
    end

    fire = mvalid && hif.hit_ready;
    ns = mscore + (fire ? HP : 0);
`ifdef MISS_PENALTY_EN
    if (miss) ns = ns - 50;
`endif
    mscore = (ns < 0) ? 0 : (ns > SMAX) ? SMAX : ns;

    load = !mvalid || hif.hit_ready;
    opend = mpend;
    if (load) begin
      mvalid = opend[0] || opend[1];
      if (opend[0]) begin mout_idx = mpidx[0]; mout_slot = 0; mpend[0] = 0; end
      else if (opend[1]) begin mout_idx = mpidx[1]; mout_slot = 1; mpend[1] = 0; end
    end
    for (int s = 0; s < 2; s++)
      if (hit[s] && !opend[s]) begin mpend[s] = 1; mpidx[s] = midx[s]; end

    cyc++;
    for (int s = 0; s < 2; s++) begin
      if (chg[s]) mst[s] = (in[s] < 10) ? M_ARMED : M_EMPTY;
      else if (hit[s]) begin mst[s] = M_FLASH; mstart[s] = cyc; end
      else if (mst[s] == M_FLASH && cyc - mstart[s] >= FL) mst[s] = M_LOCKED;
      midx[s] = in[s];
    end
  endtask

  function automatic logic [NT-1:0] mleds();
    logic [NT-1:0] v = '0;
    for (int s = 0; s < 2; s++) begin
      if (mst[s] == M_ARMED) v[midx[s]] = 1'b1;
      else if (mst[s] == M_FLASH && (((cyc - mstart[s]) / (FL / 8)) % 2) == 1) v[midx[s]] = 1'b1;
    end
    return v;
  endfunction

  task automatic compare();
    check("leds", leds, mleds());
    check("valid", hif.hit_valid, mvalid);
    if (mvalid) begin
      check("index", hif.hit_index, mout_idx);
      check("slot", hif.hit_slot, mout_slot);
    end
    check("score", score, mscore);
  endtask

  task automatic step();
    @(posedge clock);
    model_update();
    @(negedge clock);
    compare();
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  task automatic hit_channel(input int ch, input int nlow);
    photo[ch] = 1'b0;
    hold(nlow);
    photo[ch] = 1'b1;
    hold(8);
  endtask

  int n, s0;
  bit seen;

  initial begin
    hif.hit_ready = 1'b1;
    #1;
    check("rst_leds", leds, 0);
    check("rst_valid", hif.hit_valid, 0);
    check("rst_index", hif.hit_index, 0);
    check("rst_slot", hif.hit_slot, 0);
    check("rst_score", score, 0);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Basic hit on slot A with latency measurement
    ta = 4'd3; tb = 4'd10;
    hold(2);
    photo[3] = 1'b0;
    n = 0;
    while (n < 20) begin
      step();
      n++;
      if (hif.hit_valid) break;
    end
    check("latency", n, DB + 3);
    check("basic_index", hif.hit_index, 3);
    check("basic_slot", hif.hit_slot, 0);
    hold(10 - n);
    photo[3] = 1'b1;
    hold(25);
    check("basic_score", score, 100);

    // Short glitch must not register
    ta = 4'd5;
    hold(2);
    photo[5] = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin step(); seen |= hif.hit_valid; end
    photo[5] = 1'b1;
    for (int i = 0; i < 12; i++) begin step(); seen |= hif.hit_valid; end
    check("bounce_valid", seen, 0);
    check("bounce_led5", leds[5], 1);

    // Simultaneous hits with a stalled controller
    hif.hit_ready = 1'b0;
    ta = 4'd1; tb = 4'd8;
    hold(2);
    s0 = score;
    photo[1] = 1'b0; photo[8] = 1'b0;
    hold(7);
    photo[1] = 1'b1; photo[8] = 1'b1;
    hold(5);
    check("simul_a_valid", hif.hit_valid, 1);
    check("simul_a_index", hif.hit_index, 1);
    check("simul_a_slot", hif.hit_slot, 0);
    hif.hit_ready = 1'b1;
    step();
    check("simul_b_index", hif.hit_index, 8);
    check("simul_b_slot", hif.hit_slot, 1);
    step();
    check("simul_score", score, s0 + 200);
    hold(10);

    // Locked target ignores hits until re-armed
    ta = 4'd3; tb = 4'd10;
    hold(1);
    hit_channel(3, 7);
    hold(12);
    s0 = score;
    hit_channel(3, 7);
    check("locked_ignore", score, s0);
    ta = 4'd4; hold(1);
    ta = 4'd3; hold(1);
    hit_channel(3, 7);
    check("rearm_score", score, s0 + 100);

    // Saturation
    for (int k = 0; k < 100; k++) begin
      ta = 4'd3; hold(1);
      hit_channel(3, 7);
      ta = 4'd10; hold(1);
    end
    check("sat_score", score, SMAX);

    // Unarmed hit from a saturated score
    ta = 4'd10; tb = 4'd10;
    hold(2);
    hit_channel(0, 7);
`ifdef MISS_PENALTY_EN
    check("miss_score", score, SMAX - 50);
`else
    check("miss_score", score, SMAX);
`endif

    // Reset in the middle of a flash
    ta = 4'd3;
    hold(2);
    photo[3] = 1'b0;
    hold(8);
    reset = 1'b1;
    #1;
    check("midrst_leds", leds, 0);
    check("midrst_valid", hif.hit_valid, 0);
    check("midrst_index", hif.hit_index, 0);
    check("midrst_slot", hif.hit_slot, 0);
    check("midrst_score", score, 0);
    photo = '1;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    hold(2);

    // Unarmed hit at zero score stays at zero
    hit_channel(0, 7);
    check("floor_score", score, 0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NT; i++) if ($urandom_range(0, 9) == 0) photo[i] = ~photo[i];
      if ($urandom_range(0, 40) == 0) ta = 4'($urandom_range(0, 12));
      if ($urandom_range(0, 40) == 0) tb = ($urandom_range(0, 3) == 0) ? ta : 4'($urandom_range(0, 12));
      hif.hit_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
